// File: rtl/vx_mem_rsp_router.sv
// Steers one L2 response stream to NUM_OUTPUTS L1 ports by the tag's low select bits, stripping them.
// One-cycle registered latency; each output has a 2-entry buffer so input ready never depends on rsp_ready.

module vx_mem_rsp_router_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic             pop;

  assign head_vld_o = (count_q != 2'd0);
  assign head_dat_o = ent0_q;
  assign full_o     = (count_q == 2'd2);
  assign pop        = head_vld_o & pop_rdy_i;

  always_comb begin
    count_d = count_q + {1'b0, push_vld_i} - {1'b0, pop};
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (pop) begin
      ent0_d = ent1_q;
    end
    // The write slot is the first free one after this cycle's pop has shifted the head.
    if (push_vld_i) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        ent0_d = push_dat_i;
      end else begin
        ent1_d = push_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end
endmodule

module vx_mem_rsp_router #(
  parameter int NUM_OUTPUTS   = 2,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_OUT_WIDTH = 16,
  parameter int SEL_BITS      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 0,
  parameter int TAG_IN_WIDTH  = TAG_OUT_WIDTH + SEL_BITS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data,
  input  logic [TAG_IN_WIDTH-1:0]             mem_rsp_tag,
  output logic                                mem_rsp_ready,
  output logic [NUM_OUTPUTS-1:0]              rsp_valid,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   rsp_data,
  output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] rsp_tag,
  input  logic [NUM_OUTPUTS-1:0]              rsp_ready,
  output logic                                bad_sel,
  output logic [7:0]                          drop_count
);
  localparam int SELW  = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int ENT_W = DATA_WIDTH + TAG_OUT_WIDTH;

  logic [SELW-1:0]          sel;
  logic                     sel_ok;
  logic                     sel_full;
  logic                     accept;
  logic                     drop;
  logic [TAG_OUT_WIDTH-1:0] tag_strip;
  logic [NUM_OUTPUTS-1:0]   full;
  logic                     bad_sel_q, bad_sel_d;
  logic [7:0]               drop_count_q, drop_count_d;

  generate
    if (SEL_BITS > 0) begin : g_sel
      assign sel = mem_rsp_tag[SEL_BITS-1:0];
    end else begin : g_nosel
      assign sel = '0;
    end
  endgenerate

  assign tag_strip = mem_rsp_tag[TAG_IN_WIDTH-1 -: TAG_OUT_WIDTH];
  assign sel_ok    = (32'(sel) < 32'(NUM_OUTPUTS));

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (sel == SELW'(i)) sel_full = full[i];
    end
  end

  // Out-of-range indices are always accepted so a stray response can never wedge the return path.
  assign mem_rsp_ready = ~sel_ok | ~sel_full;
  assign accept        = mem_rsp_valid & mem_rsp_ready;
  assign drop          = accept & ~sel_ok;

  generate
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
      logic [ENT_W-1:0] head_dat;

      vx_mem_rsp_router_fifo2 #(.WIDTH(ENT_W)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_vld_i (accept & sel_ok & (sel == SELW'(i))),
        .push_dat_i ({mem_rsp_data, tag_strip}),
        .pop_rdy_i  (rsp_ready[i]),
        .head_vld_o (rsp_valid[i]),
        .head_dat_o (head_dat),
        .full_o     (full[i])
      );

      assign rsp_data[i*DATA_WIDTH +: DATA_WIDTH]       = head_dat[ENT_W-1 -: DATA_WIDTH];
      assign rsp_tag[i*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]  = head_dat[TAG_OUT_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    bad_sel_d    = bad_sel_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_sel_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      bad_sel_q    <= bad_sel_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bad_sel    = bad_sel_q;
  assign drop_count = drop_count_q;
endmodule
